// File: rtl/fetch_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue_if
// Description : Handshake bundle between fetch, the fetch/decode queue and
//               decode. Signal suffixes (_i/_o) are named from the queue's
//               point of view, so the slave modport is the queue itself and
//               the master modport is the surrounding fetch/decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_decode_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Pipeline control
   logic              flush_i;

   // Fetch side (push)
   logic              valid_i;
   logic              ready_o;
   logic [XLEN-1:0]   pc_i;
   logic [31:0]       instr_i;
   logic              xcpt_i;

   // Decode side (pop)
   logic              valid_o;
   logic              ready_i;
   logic [XLEN-1:0]   pc_o;
   logic [31:0]       instr_o;
   logic              xcpt_o;

   // Occupancy
   logic [CNT_W-1:0]  count_o;

   // Fetch/decode environment driving the queue
   modport master (
      output flush_i,
      output valid_i,
      input  ready_o,
      output pc_i,
      output instr_i,
      output xcpt_i,
      input  valid_o,
      output ready_i,
      input  pc_o,
      input  instr_o,
      input  xcpt_o,
      input  count_o
   );

   // The queue
   modport slave (
      input  flush_i,
      input  valid_i,
      output ready_o,
      input  pc_i,
      input  instr_i,
      input  xcpt_i,
      output valid_o,
      input  ready_i,
      output pc_o,
      output instr_o,
      output xcpt_o,
      output count_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue
// Description : Elastic FIFO of {pc, instr, xcpt} tuples between fetch and
//               decode. Occupancy counter distinguishes full from empty;
//               ready toward fetch depends only on registered state. A flush
//               empties the queue and cancels any same-cycle push/pop.
//               Optional macro FETCH_DECODE_QUEUE_BYPASS_EN enables a
//               zero-latency combinational path from fetch to decode while
//               the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  wire                  clk_i,
   input  wire                  rstn_i,
   fetch_decode_queue_if.slave  bus
);
   localparam int                PTR_W        = $clog2(DEPTH);
   localparam int                CNT_W        = PTR_W + 1;
   localparam logic [31:0]       C_NOP_INSTR  = 32'h0000_0013;
   localparam logic [CNT_W-1:0]  C_FULL_COUNT = CNT_W'(DEPTH);

   // Storage (data only; validity is tracked by the counter)
   logic [XLEN-1:0]  r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];
   logic             r_xcpt_mem  [DEPTH];

   // Control state
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Derived control
   logic             w_empty;
   logic             w_full;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic             w_store;
   logic             w_advance;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL_COUNT);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
   // Empty queue forwards the incoming entry straight to decode.
   assign w_bypass = w_empty && bus.valid_i && !bus.flush_i;
`else
   assign w_bypass = 1'b0;
`endif

   // ready_o is purely a function of the registered count, so a full queue
   // never accepts a push even when decode pops in the same cycle.
   assign bus.ready_o = !w_full;
   assign bus.valid_o = !w_empty || w_bypass;
   assign bus.count_o = r_count;

   // Handshakes; flush cancels both directions.
   assign w_push = bus.valid_i && !w_full && !bus.flush_i;
   assign w_pop  = bus.valid_o && bus.ready_i && !bus.flush_i;

   // A bypassed entry consumed in the same cycle is neither stored nor
   // popped from storage; a bypassed entry not consumed is stored normally.
   assign w_store   = w_push && !(w_bypass && bus.ready_i);
   assign w_advance = w_pop && !w_bypass;

   // Head presentation: stored head, else bypassed input, else a NOP.
   always_comb begin
      bus.pc_o    = '0;
      bus.instr_o = C_NOP_INSTR;
      bus.xcpt_o  = 1'b0;
      if (!w_empty) begin
         bus.pc_o    = r_pc_mem[r_rd_ptr];
         bus.instr_o = r_instr_mem[r_rd_ptr];
         bus.xcpt_o  = r_xcpt_mem[r_rd_ptr];
      end else if (w_bypass) begin
         bus.pc_o    = bus.pc_i;
         bus.instr_o = bus.instr_i;
         bus.xcpt_o  = bus.xcpt_i;
      end
   end

   // Pointer and occupancy update; flush returns everything to the origin.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_advance) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_advance);
      end
   end

   // Entry write; contents need no reset because the counter gates them.
   always_ff @(posedge clk_i) begin
      if (w_store) begin
         r_pc_mem[r_wr_ptr]    <= bus.pc_i;
         r_instr_mem[r_wr_ptr] <= bus.instr_i;
         r_xcpt_mem[r_wr_ptr]  <= bus.xcpt_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_queue
// Description : Self-checking bench for fetch_decode_queue. A queue-based
//               reference model is compared against the DUT every cycle,
//               plus hand-computed literal expectations per scenario.
//               Honours FETCH_DECODE_QUEUE_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_queue;
   localparam int          DEPTH = 4;
   localparam int          XLEN  = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            xcpt;
   } ent_t;

   logic clk;
   logic rstn;

   fetch_decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

   fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   ent_t            mdl_q   [$];
   logic [XLEN-1:0] out_log [$];
   logic [XLEN-1:0] all_log [$];

   logic [31:0] t2_instr [4] = '{32'h0050_0093, 32'h00A0_0113,
                                 32'h0020_81B3, 32'hFE00_0EE3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // Model: does the empty queue forward the input this cycle?
   function automatic logic m_bypass();
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      return (mdl_q.size() == 0) && bus.valid_i && !bus.flush_i;
`else
      return 1'b0;
`endif
   endfunction

   // Model state update on each clock / reset
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mdl_q.delete();
      end else if (bus.flush_i) begin
         mdl_q.delete();
      end else begin
         automatic logic byp  = m_bypass();
         automatic logic push = bus.valid_i && (mdl_q.size() != DEPTH);
         automatic logic pop  = ((mdl_q.size() != 0) || byp) && bus.ready_i;
         automatic ent_t e;
         e.pc = bus.pc_i; e.instr = bus.instr_i; e.xcpt = bus.xcpt_i;
         if (!(byp && bus.ready_i)) begin
            if (pop) void'(mdl_q.pop_front());
            if (push) mdl_q.push_back(e);
         end
      end
   end

   // Per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      automatic logic            e_valid;
      automatic logic [XLEN-1:0] e_pc    = '0;
      automatic logic [31:0]     e_instr = NOP;
      automatic logic            e_xcpt  = 1'b0;
      e_valid = (mdl_q.size() != 0) || m_bypass();
      if (mdl_q.size() != 0) begin
         e_pc = mdl_q[0].pc; e_instr = mdl_q[0].instr; e_xcpt = mdl_q[0].xcpt;
      end else if (m_bypass()) begin
         e_pc = bus.pc_i; e_instr = bus.instr_i; e_xcpt = bus.xcpt_i;
      end
      chk("valid_o", 64'(bus.valid_o), 64'(e_valid));
      chk("ready_o", 64'(bus.ready_o), 64'(mdl_q.size() != DEPTH));
      chk("count_o", 64'(bus.count_o), 64'(mdl_q.size()));
      chk("pc_o",    64'(bus.pc_o),    64'(e_pc));
      chk("instr_o", 64'(bus.instr_o), 64'(e_instr));
      chk("xcpt_o",  64'(bus.xcpt_o),  64'(e_xcpt));
      if (rstn && bus.valid_o && bus.ready_i && !bus.flush_i) begin
         out_log.push_back(bus.pc_o);
         all_log.push_back(bus.pc_o);
      end
   end

   task automatic set_in(input logic v, input logic [XLEN-1:0] pc,
                         input logic [31:0] instr, input logic x,
                         input logic rdy, input logic fl);
      bus.valid_i = v;   bus.pc_i  = pc;  bus.instr_i = instr;
      bus.xcpt_i  = x;   bus.ready_i = rdy; bus.flush_i = fl;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hits;
      rstn = 1'b0;
      set_in(0, '0, '0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Reset / idle state
      @(negedge clk);
      chk("rst_valid", 64'(bus.valid_o), 64'd0);
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      chk("rst_count", 64'(bus.count_o), 64'd0);
      chk("rst_instr", 64'(bus.instr_o), 64'h13);
      chk("rst_pc",    64'(bus.pc_o),    64'd0);
      next();

      // Fill to full with decode stalled, then attempt a 5th push
      out_log.delete();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 64'h1000 + 64'(4 * i), t2_instr[i], 0, 0, 0);
         next();
      end
      set_in(1, 64'h1010, 32'h0000_0033, 0, 0, 0);
      @(negedge clk);
      chk("full_count", 64'(bus.count_o), 64'd4);
      chk("full_ready", 64'(bus.ready_o), 64'd0);
      chk("full_head",  64'(bus.pc_o),    64'h1000);
      chk("full_instr", 64'(bus.instr_o), 64'h0050_0093);
      next();
      chk("full_hold",  64'(bus.count_o), 64'd4);
      set_in(0, '0, '0, 0, 1, 0);
      repeat (4) next();
      @(negedge clk);
      chk("drain_valid", 64'(bus.valid_o), 64'd0);
      next();
      chk("drain_n", 64'(out_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < out_log.size(); i++)
         chk("drain_order", 64'(out_log[i]), 64'h1000 + 64'(4 * i));

      // Steady stream, ready held high, pointers wrap several times
      out_log.delete();
      for (int i = 0; i < 20; i++) begin
         set_in(1, 64'h5000 + 64'(4 * i), 32'h1000_0000 + 32'(i), 0, 1, 0);
         @(negedge clk);
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
         chk("stream_count", 64'(bus.count_o), 64'd0);
`else
         chk("stream_count", 64'(bus.count_o), (i == 0) ? 64'd0 : 64'd1);
`endif
         @(posedge clk);
         #1;
      end
      set_in(0, '0, '0, 0, 1, 0);
      repeat (2) next();
      chk("stream_n", 64'(out_log.size()), 64'd20);
      for (int i = 0; i < 20 && i < out_log.size(); i++)
         chk("stream_order", 64'(out_log[i]), 64'h5000 + 64'(4 * i));

      // Flush with a same-cycle push
      out_log.delete();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 64'h6000 + 64'(4 * i), 32'h2000_0000 + 32'(i), 0, 0, 0);
         next();
      end
      set_in(1, 64'h2000, 32'h0000_0067, 0, 0, 1);
      next();
      set_in(0, '0, '0, 0, 1, 0);
      @(negedge clk);
      chk("flush_count", 64'(bus.count_o), 64'd0);
      chk("flush_valid", 64'(bus.valid_o), 64'd0);
      chk("flush_ready", 64'(bus.ready_o), 64'd1);
      repeat (3) next();
      chk("flush_no_out", 64'(out_log.size()), 64'd0);

      // Faulting entry is carried through untouched
      set_in(1, 64'h3000, 32'hFFFF_FFFF, 1, 0, 0);
      next();
      set_in(0, '0, '0, 0, 0, 0);
      @(negedge clk);
      chk("xcpt_flag",  64'(bus.xcpt_o),  64'd1);
      chk("xcpt_instr", 64'(bus.instr_o), 64'hFFFF_FFFF);
      chk("xcpt_pc",    64'(bus.pc_o),    64'h3000);
      next();
      @(negedge clk);
      chk("xcpt_hold",  64'(bus.pc_o),    64'h3000);
      next();
      set_in(0, '0, '0, 0, 1, 0);
      next();
      set_in(0, '0, '0, 0, 0, 0);
      next();

      // Empty queue, push with decode ready: bypass vs one-cycle latency
      set_in(1, 64'h4000, 32'h0010_0073, 0, 1, 0);
      @(negedge clk);
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      chk("byp_valid", 64'(bus.valid_o), 64'd1);
      chk("byp_pc",    64'(bus.pc_o),    64'h4000);
      chk("byp_count", 64'(bus.count_o), 64'd0);
`else
      chk("lat_valid0", 64'(bus.valid_o), 64'd0);
      chk("lat_pc0",    64'(bus.pc_o),    64'd0);
`endif
      next();
      set_in(0, '0, '0, 0, 1, 0);
      @(negedge clk);
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      chk("byp_after",  64'(bus.valid_o), 64'd0);
      chk("byp_count1", 64'(bus.count_o), 64'd0);
`else
      chk("lat_valid1", 64'(bus.valid_o), 64'd1);
      chk("lat_pc1",    64'(bus.pc_o),    64'h4000);
      chk("lat_count1", 64'(bus.count_o), 64'd1);
`endif
      repeat (2) next();

      // Asynchronous reset in the middle of a cycle
      set_in(1, 64'h7000, 32'h0000_0001, 0, 0, 0);
      next();
      set_in(1, 64'h7004, 32'h0000_0002, 0, 0, 0);
      next();
      set_in(0, '0, '0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      chk("arst_count", 64'(bus.count_o), 64'd0);
      chk("arst_valid", 64'(bus.valid_o), 64'd0);
      chk("arst_instr", 64'(bus.instr_o), 64'h13);
      chk("arst_ready", 64'(bus.ready_o), 64'd1);
      @(posedge clk);
      #1 rstn = 1'b1;
      next();
      chk("arst_after", 64'(bus.count_o), 64'd0);

      hits = 0;
      foreach (all_log[i]) if (all_log[i] == 64'h2000) hits++;
      chk("flushed_pc_never_out", 64'(hits), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
